// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit unsigned subtractor, LSB first, single borrow flop.
// Operands load byte-wide from ui_in; the result and flags hold until the next completion.
module tt_um_serial_subtractor (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] a_sh;
    logic [7:0] b_sh;
    logic [7:0] d_sh;
    logic       br;
    logic [2:0] cnt;
    logic       borrow;
    logic       zero;

    logic       load_a;
    logic       load_b;
    logic       start;
    logic       go;
    logic       last;
    logic       bit_a;
    logic       bit_b;
    logic       d;
    logic       br_nx;
    logic [7:0] d_nx;
    logic       busy;
    logic       done;
    logic       unused_pins;

    assign load_a      = uio_in[0];
    assign load_b      = uio_in[1];
    assign start       = uio_in[2];
    assign unused_pins = &{1'b0, ena, uio_in[7:3]};

    assign go    = start && (state != SHIFT);
    assign last  = (state == SHIFT) && (cnt == 3'd7);
    assign bit_a = a_sh[0];
    assign bit_b = b_sh[0];
    assign d     = bit_a ^ bit_b ^ br;
    assign br_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    assign d_nx  = {d, d_sh[7:1]};

    assign busy    = (state == SHIFT);
    assign done    = (state == DONE);
    assign uio_out = {zero, borrow, done, busy, 4'h0};
    assign uio_oe  = 8'hF0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = go ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand registers are independent of the working copies, so loads
    // at any time only affect the next started operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= 8'h00;
            b_reg <= 8'h00;
        end else begin
            if (load_a) a_reg <= ui_in;
            if (load_b) b_reg <= ui_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= 8'h00;
            b_sh   <= 8'h00;
            d_sh   <= 8'h00;
            br     <= 1'b0;
            cnt    <= 3'd0;
            uo_out <= 8'h00;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else if (go) begin
            a_sh <= a_reg;
            b_sh <= b_reg;
            br   <= 1'b0;
            cnt  <= 3'd0;
        end else if (state == SHIFT) begin
            a_sh <= {1'b0, a_sh[7:1]};
            b_sh <= {1'b0, b_sh[7:1]};
            d_sh <= d_nx;
            br   <= br_nx;
            cnt  <= cnt + 3'd1;
            if (last) begin
                uo_out <= d_nx;
                borrow <= br_nx;
                zero   <= (d_nx == 8'h00);
            end
        end
    end

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed bench for tt_um_serial_subtractor: vector table plus
// hand-written sequences for overlap, same-edge load, reset and back-to-back.
module tb_tt_um_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;
    logic [7:0] prev_uo;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       z;
    } vec_t;

    vec_t vecs [6];

    tt_um_serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        ui_in  = a;
        uio_in = 8'h01;
        @(negedge clk);
        ui_in  = b;
        uio_in = 8'h02;
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    // Returns just after start edge k with start released.
    task automatic pulse_start();
        @(negedge clk);
        uio_in = 8'h04;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
    endtask

    // Called just after edge k; returns just after edge k+8.
    // inject: load A=FF with start before edge k+3.
    task automatic finish_op(input string nm, input logic [7:0] ed,
                             input logic eb, input logic ez, input logic inject);
        int busy_cnt;
        int done_cnt;
        busy_cnt = int'(uio_out[4]);
        done_cnt = int'(uio_out[5]);
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (inject && i == 2) begin
                ui_in  = 8'hFF;
                uio_in = 8'h05;
            end
            if (inject && i == 3) uio_in = 8'h00;
            busy_cnt += int'(uio_out[4]);
            done_cnt += int'(uio_out[5]);
            if (i == 4) check({nm, " hold"}, uo_out, prev_uo);
        end
        check({nm, " busy cycles"}, 8'(busy_cnt), 8'd8);
        check({nm, " early done"}, 8'(done_cnt), 8'd0);
        @(posedge clk);
        #1;
        check({nm, " done"}, {6'b0, uio_out[5:4]}, 8'b10);
        check({nm, " result"}, uo_out, ed);
        check({nm, " borrow"}, {7'b0, uio_out[6]}, {7'b0, eb});
        check({nm, " zero"}, {7'b0, uio_out[7]}, {7'b0, ez});
        prev_uo = ed;
    endtask

    task automatic after_done(input string nm);
        @(posedge clk);
        #1;
        check({nm, " idle"}, {6'b0, uio_out[5:4]}, 8'b00);
    endtask

    initial begin
        int dcnt;
        checks  = 0;
        errors  = 0;
        prev_uo = 8'h00;
        ena     = 1'b1;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        rst_n   = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h7F, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h81, 8'hFF, 1'b1, 1'b0};

        #12;
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            load_ops(vecs[i].a, vecs[i].b);
            pulse_start();
            finish_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].br, vecs[i].z, 1'b0);
            after_done($sformatf("vec%0d", i));
        end

        // Load and start mid-operation must not disturb it.
        load_ops(8'h10, 8'h01);
        pulse_start();
        finish_op("overlap", 8'h0F, 1'b0, 1'b0, 1'b1);
        after_done("overlap");
        pulse_start();
        finish_op("overlap next", 8'hFE, 1'b0, 1'b0, 1'b0);
        after_done("overlap next");

        // Load on the start edge affects only the following operation.
        load_ops(8'h09, 8'h04);
        @(negedge clk);
        ui_in  = 8'h20;
        uio_in = 8'h05;
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        finish_op("same edge", 8'h05, 1'b0, 1'b0, 1'b0);
        after_done("same edge");
        pulse_start();
        finish_op("same edge next", 8'h1C, 1'b0, 1'b0, 1'b0);
        after_done("same edge next");

        // Back-to-back with start held high throughout.
        load_ops(8'h0A, 8'h03);
        @(negedge clk);
        uio_in = 8'h04;
        @(posedge clk);
        #1;
        finish_op("b2b first", 8'h07, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("b2b restart", {6'b0, uio_out[5:4]}, 8'b01);
        uio_in = 8'h00;
        finish_op("b2b second", 8'h07, 1'b0, 1'b0, 1'b0);
        after_done("b2b second");

        // Reset mid-shift aborts without done or result update.
        load_ops(8'h33, 8'h11);
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort uo_out", uo_out, 8'h00);
        check("abort uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            dcnt += int'(uio_out[5]);
        end
        check("abort no done", 8'(dcnt), 8'd0);
        check("abort result", uo_out, 8'h00);
        prev_uo = 8'h00;
        pulse_start();
        finish_op("post reset", 8'h00, 1'b0, 1'b1, 1'b0);
        after_done("post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
